bus_arbiter_rr: RTL and testbench

Parametrised N-master bus arbiter with registered one-hot grant. It extends the two-master park-on-M0 arbiter to N masters with round-robin selection and a per-owner hold quantum that forces rotation under contention. It sits between the masters' request lines and the bus mux and drives the mux select (`grant_id`) and the per-master grants.

---
 rtl/bus_arbiter_rr.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin bus arbiter with a registered one-hot grant.
// The owner keeps the bus while it requests. Under contention it is preempted after
// QUANTUM consecutive held cycles. With no requests the bus parks on PARK_ID.
// Every output comes straight from a flop, so there is no combinational path
// from req to grant, grant_id or rotate.
module bus_arbiter_rr #(
    parameter int N_MASTER = 4,
    parameter int QUANTUM  = 8,
    parameter int PARK_ID  = 0,
    localparam int IDW     = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
    localparam int CW      = (QUANTUM > 2) ? $clog2(QUANTUM) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] grant,
    output logic [IDW-1:0]      grant_id,
    output logic                rotate
);

    localparam logic [IDW-1:0] C_PARK = IDW'(PARK_ID);
    localparam logic [IDW:0]   C_N    = (IDW+1)'(N_MASTER);
    localparam logic [CW-1:0]  C_LAST = CW'((QUANTUM == 0) ? 0 : QUANTUM - 1);
    localparam bit             C_QEN  = (QUANTUM != 0);

    // Per-edge decision, evaluated in priority order.
    typedef enum logic [1:0] {
        D_KEEP    = 2'd0,
        D_PREEMPT = 2'd1,
        D_RELEASE = 2'd2,
        D_PARK    = 2'd3
    } decision_t;

    logic [IDW-1:0]      r_owner;
    logic [CW-1:0]       r_cnt;
    logic [N_MASTER-1:0] r_grant;
    logic                r_rotate;

    logic [IDW-1:0]      w_cand_idx [N_MASTER];
    logic [N_MASTER-1:0] w_cand_req;
    logic [IDW-1:0]      w_rr_id;
    logic                w_own_req;
    logic                w_others;
    logic                w_expired;
    decision_t           w_decision;
    logic [IDW-1:0]      w_owner_next;
    logic [CW-1:0]       w_cnt_next;
    logic                w_rotate_next;
    logic [N_MASTER-1:0] w_grant_next;

    // r_grant is always one-hot(r_owner), so it doubles as the owner mask.
    assign w_own_req = |(req & r_grant);
    assign w_others  = |(req & ~r_grant);
    assign w_expired = C_QEN && (r_cnt == C_LAST);

    // Candidate gi is the master gi places past the owner, modulo N_MASTER.
    // Offset 0 is the owner itself and is never chosen by the search.
    genvar gi;
    generate
        for (gi = 0; gi < N_MASTER; gi++) begin : g_cand
            logic [IDW:0] w_sum;
            assign w_sum           = {1'b0, r_owner} + (IDW+1)'(gi);
            assign w_cand_idx[gi]  = (w_sum >= C_N) ? IDW'(w_sum - C_N) : IDW'(w_sum);
            assign w_cand_req[gi]  = req[w_cand_idx[gi]];
        end
    endgenerate

    // Circular search from owner+1: the nearest requesting candidate wins.
    always_comb begin
        w_rr_id = r_owner;
        for (int k = N_MASTER - 1; k >= 1; k--) begin
            if (w_cand_req[k]) begin
                w_rr_id = w_cand_idx[k];
            end
        end
    end

    // Classify the coming edge as keep, preempt, release or park.
    always_comb begin
        w_decision = D_PARK;
        if (req == '0) begin
            w_decision = D_PARK;
        end else if (w_own_req) begin
            w_decision = (w_expired && w_others) ? D_PREEMPT : D_KEEP;
        end else begin
            w_decision = D_RELEASE;
        end
    end

    // Next owner, hold count and rotate pulse for each decision.
    always_comb begin
        w_owner_next  = r_owner;
        w_cnt_next    = '0;
        w_rotate_next = 1'b0;
        case (w_decision)
            D_KEEP: begin
                w_owner_next = r_owner;
                // An uncontended owner at the limit simply restarts its count.
                if (C_QEN && !w_expired) begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            D_PREEMPT: begin
                w_owner_next  = w_rr_id;
                w_rotate_next = 1'b1;
            end
            D_RELEASE: begin
                w_owner_next = w_rr_id;
            end
            default: begin
                w_owner_next = C_PARK;
            end
        endcase
    end

    // One-hot decode of the next owner so the grant vector is a plain flop.
    generate
        for (gi = 0; gi < N_MASTER; gi++) begin : g_onehot
            assign w_grant_next[gi] = (w_owner_next == IDW'(gi));
        end
    endgenerate

    // State register; reset parks the bus and suppresses any rotate pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner  <= C_PARK;
            r_cnt    <= '0;
            r_grant  <= N_MASTER'(1) << PARK_ID;
            r_rotate <= 1'b0;
        end else begin
            r_owner  <= w_owner_next;
            r_cnt    <= w_cnt_next;
            r_grant  <= w_grant_next;
            r_rotate <= w_rotate_next;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_owner;
    assign rotate   = r_rotate;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr with N_MASTER=4, QUANTUM=4, PARK_ID=0.
// The driver applies req at each falling edge and queues the outcome expected after
// the next rising edge. The monitor pops and compares shortly after each rising edge.
module tb_bus_arbiter_rr;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       rotate;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       rot;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];

    bus_arbiter_rr #(
        .N_MASTER(4),
        .QUANTUM (4),
        .PARK_ID (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .grant_id(grant_id),
        .rotate  (rotate)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got grant=%b id=%0d rot=%b, want grant=%b id=%0d rot=%b",
                     nm, act[6:3], act[2:1], act[0], want[6:3], want[2:1], want[0]);
        end else begin
            $display("ok   %s: grant=%b id=%0d rot=%b", nm, act[6:3], act[2:1], act[0]);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input string nm, input logic [3:0] r,
                        input logic [3:0] g, input logic [1:0] id, input logic rot);
        exp_t e;
        req   = r;
        e.g   = g;
        e.id  = id;
        e.rot = rot;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge, checks the parked state immediately and
    // while held, then releases at a falling edge with req = r_after.
    task automatic do_reset(input logic [3:0] r_hold, input logic [3:0] r_after);
        reset = 1'b1;
        req   = r_hold;
        #1;
        check("reset_immediate", {grant, grant_id, rotate}, 7'b0001_00_0);
        repeat (2) begin
            @(negedge clk);
            check("reset_held", {grant, grant_id, rotate}, 7'b0001_00_0);
        end
        reset = 1'b0;
        req   = r_after;
    endtask

    // Monitor: one comparison per queued expectation, sampled after the rising edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {grant, grant_id, rotate}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Reset with every master requesting, then fair rotation from release.
        do_reset(4'b1111, 4'b1111);
        check("fair_pre_edge", {grant, grant_id, rotate}, 7'b0001_00_0);
        for (int e = 1; e < 20; e++) begin
            step("fair", 4'b1111, 4'(4'b0001 << ((e / 4) % 4)), 2'((e / 4) % 4),
                 (e % 4) == 0);
        end

        // Idle request from park, then back to park.
        do_reset(4'b0000, 4'b0000);
        step("idle_req",  4'b0100, 4'b0100, 2'd2, 1'b0);
        step("idle_park", 4'b0000, 4'b0001, 2'd0, 1'b0);

        // Release with wrap.
        step("wrap_own3",  4'b1000, 4'b1000, 2'd3, 1'b0);
        step("wrap_to1",   4'b0110, 4'b0010, 2'd1, 1'b0);
        step("wrap_own2",  4'b0100, 4'b0100, 2'd2, 1'b0);
        step("wrap_to3",   4'b1011, 4'b1000, 2'd3, 1'b0);

        // Quantum without contention.
        do_reset(4'b0000, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step("no_contend", 4'b0010, 4'b0010, 2'd1, 1'b0);
        end

        // Asynchronous reset mid-hold: owner 3 with cnt=2.
        do_reset(4'b0000, 4'b0000);
        step("mid_own3", 4'b1000, 4'b1000, 2'd3, 1'b0);
        step("mid_own3", 4'b1000, 4'b1000, 2'd3, 1'b0);
        step("mid_own3", 4'b1000, 4'b1000, 2'd3, 1'b0);
        do_reset(4'b1000, 4'b1000);
        step("hold_c0",  4'b1000, 4'b1000, 2'd3, 1'b0);
        step("hold_c1",  4'b1001, 4'b1000, 2'd3, 1'b0);
        step("hold_c2",  4'b1001, 4'b1000, 2'd3, 1'b0);
        step("hold_c3",  4'b1001, 4'b1000, 2'd3, 1'b0);
        step("preempt",  4'b1001, 4'b0001, 2'd0, 1'b1);
        step("rot_drop", 4'b1001, 4'b0001, 2'd0, 1'b0);

        // Drain and make sure every expectation was consumed.
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
